// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide over XLEN cycles, followed by a sign-fix cycle.
module mdu_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned PROD_W = 2 * XLEN;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        func3_q, func3_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              div0_q, div0_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   op_q, op_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Operand decode for the accepting edge
    logic              is_div;
    logic              a_signed, b_signed;
    logic              neg_a_in, neg_b_in;
    logic [XLEN-1:0]   mag_a, mag_b;

    // Datapath intermediates
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [PROD_W-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign is_div   = func3[2];
    assign a_signed = (func3 == F3_MULH) || (func3 == F3_MULHSU) ||
                      (func3 == F3_DIV)  || (func3 == F3_REM);
    assign b_signed = (func3 == F3_MULH) || (func3 == F3_DIV) || (func3 == F3_REM);
    assign neg_a_in = a_signed & rs1[XLEN-1];
    assign neg_b_in = b_signed & rs2[XLEN-1];
    // 0x80000000 negates to itself, which read as unsigned is its magnitude
    assign mag_a    = neg_a_in ? (~rs1 + XLEN'(1)) : rs1;
    assign mag_b    = neg_b_in ? (~rs2 + XLEN'(1)) : rs2;

    // Multiply step: add multiplicand into the high half on LSB, then shift right
    assign mul_sum   = {1'b0, acc_q[PROD_W-1:XLEN]} +
                       (acc_q[0] ? {1'b0, op_q} : {(XLEN+1){1'b0}});

    // Restoring divide step: high half is the remainder, low half the dividend/quotient
    assign div_shift = {acc_q[PROD_W-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, op_q};
    assign div_ge    = (div_shift >= {1'b0, op_q});

    // Sign correction; divide-by-zero quotient is forced, overflow falls out naturally
    assign prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + PROD_W'(1)) : acc_q;
    assign quo_fix  = div0_q ? {XLEN{1'b1}}
                    : ((neg_a_q ^ neg_b_q) ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0]);
    assign rem_fix  = neg_a_q ? (~acc_q[PROD_W-1:XLEN] + XLEN'(1)) : acc_q[PROD_W-1:XLEN];

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        func3_d  = func3_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        div0_d   = div0_q;
        count_d  = count_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    func3_d = func3;
                    neg_a_d = neg_a_in;
                    neg_b_d = neg_b_in;
                    div0_d  = (rs2 == '0);
                    count_d = '0;
                    op_d    = is_div ? mag_b : mag_a;
                    acc_d   = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (func3_q[2]) begin
                    acc_d = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                             acc_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                unique case (func3_q)
                    F3_MUL:            result_d = prod_fix[XLEN-1:0];
                    3'b001, 3'b010,
                    3'b011:            result_d = prod_fix[PROD_W-1:XLEN];
                    3'b100, 3'b101:    result_d = quo_fix;
                    default:           result_d = rem_fix;
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            func3_q  <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            div0_q   <= 1'b0;
            count_q  <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            func3_q  <= func3_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            div0_q   <= div0_d;
            count_q  <= count_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    // Stall drops in the done cycle so the core retires on the following edge
    assign stall  = start & ~done_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed RV32M vectors, control
// scenarios and randomized ops against an arithmetic reference model.
module tb_mdu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_checks;
    int n_fail;

    mdu_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .func3  (func3),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit wraparound product of extended operands; RISC-V divide rules
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int signed   sa, sb;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea  = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
        eb  = (f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = ea * eb;
        case (f)
            3'b000:  return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issues one M-op the way the core does and reports what it observed
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit stall_bad,
                         output logic busy_after, output logic done_after);
        @(negedge clk);
        start = 1'b1; func3 = f; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        lat = 0;
        stall_bad = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (stall !== 1'b1 || busy !== 1'b1) stall_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        if (stall !== 1'b0) stall_bad = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        busy_after = busy;
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; func3 = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/stall=%b expected 000", {busy, done, stall});
        end
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 00000000", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] res; int lat; bit sb; logic ba, da;
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, res, lat, sb, ba, da);
        n_checks++;
        if (res !== 32'hFFFF_FFEB) begin
            n_fail++; $display("FAIL mul_7x-3: got %h expected ffffffeb", res);
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++; $display("FAIL mul_latency: got %0d expected 33", lat);
        end
        n_checks++;
        if (sb !== 1'b0) begin
            n_fail++; $display("FAIL mul_stall_busy: stall/busy profile wrong (flag %0d expected 0)", sb);
        end
        n_checks++;
        if ({ba, da} !== 2'b00) begin
            n_fail++; $display("FAIL mul_after_done: busy/done=%b expected 00", {ba, da});
        end
    endtask

    task automatic test_mulh();
        logic [31:0] res; int lat; bit sb; logic ba, da;
        logic [2:0]  fs  [3] = '{3'b011, 3'b001, 3'b010};
        logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) begin
            do_op(fs[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, sb, ba, da);
            n_checks++;
            if (res !== exp[i] || lat !== 33) begin
                n_fail++;
                $display("FAIL mulh_f3=%0d: got %h lat %0d expected %h lat 33", fs[i], res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] res; int lat; bit sb; logic ba, da;
        logic [2:0]  fs  [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            do_op(fs[i], as[i], bs[i], res, lat, sb, ba, da);
            n_checks++;
            if (res !== exp[i] || lat !== 33) begin
                n_fail++;
                $display("FAIL div_f3=%0d: got %h lat %0d expected %h lat 33", fs[i], res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] res; int lat; bit sb; logic ba, da;
        do_op(3'b101, 32'd5, 32'd0, res, lat, sb, ba, da);
        n_checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 33) begin
            n_fail++; $display("FAIL divu_by_zero: got %h lat %0d expected ffffffff lat 33", res, lat);
        end
        do_op(3'b110, 32'd5, 32'd0, res, lat, sb, ba, da);
        n_checks++;
        if (res !== 32'd5 || lat !== 33) begin
            n_fail++; $display("FAIL rem_by_zero: got %h lat %0d expected 00000005 lat 33", res, lat);
        end
        do_op(3'b100, 32'hFFFF_FFF9, 32'd0, res, lat, sb, ba, da);
        n_checks++;
        if (res !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL div_neg_by_zero: got %h expected ffffffff", res);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] res; int lat; bit sb; logic ba, da;
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sb, ba, da);
        n_checks++;
        if (res !== 32'h8000_0000 || lat !== 33) begin
            n_fail++; $display("FAIL div_overflow: got %h lat %0d expected 80000000 lat 33", res, lat);
        end
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sb, ba, da);
        n_checks++;
        if (res !== 32'h0) begin
            n_fail++; $display("FAIL rem_overflow: got %h expected 00000000", res);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; int lat; bit sb; logic ba, da;
        @(negedge clk);
        start = 1'b1; func3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_op: busy/done=%b result=%h expected 00 and 00000000", {busy, done}, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'b000, 32'd3, 32'd4, res, lat, sb, ba, da);
        n_checks++;
        if (res !== 32'd12 || lat !== 33) begin
            n_fail++; $display("FAIL restart_after_reset: got %h lat %0d expected 0000000c lat 33", res, lat);
        end
    endtask

    task automatic test_ignore_inputs();
        int lat;
        @(negedge clk);
        start = 1'b1; func3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
        @(posedge clk); #1;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin rs1 = 32'd9; rs2 = 32'd100; func3 = 3'b100; end
            if (lat == 8) start = 1'b0;
            if (lat == 9) start = 1'b1;
        end
        n_checks++;
        if (result !== 32'd12 || lat !== 33) begin
            n_fail++; $display("FAIL ignore_midop_changes: got %h lat %0d expected 0000000c lat 33", result, lat);
        end
        // start still high through the done cycle must not be taken as a new op
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL start_in_done_ignored: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; int lat; bit sb; logic ba, da;
        do_op(3'b101, 32'd1000, 32'd10, res, lat, sb, ba, da);
        n_checks++;
        if (res !== 32'd100 || lat !== 33) begin
            n_fail++; $display("FAIL b2b_first: got %h lat %0d expected 00000064 lat 33", res, lat);
        end
        do_op(3'b000, 32'd6, 32'd7, res, lat, sb, ba, da);
        n_checks++;
        if (res !== 32'd42 || lat !== 33) begin
            n_fail++; $display("FAIL b2b_second: got %h lat %0d expected 0000002a lat 33", res, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] res, a, b, exp; int lat; bit sb; logic ba, da; logic [2:0] f;
        for (int i = 0; i < 200; i++) begin
            f = 3'($urandom_range(0, 7));
            a = rand_operand();
            b = rand_operand();
            exp = ref_model(f, a, b);
            do_op(f, a, b, res, lat, sb, ba, da);
            n_checks++;
            if (res !== exp || lat !== 33 || sb !== 1'b0 || ba !== 1'b0 || da !== 1'b0) begin
                n_fail++;
                $display("FAIL random_%0d f3=%0d a=%h b=%h: got %h lat %0d stallflag %0d busy %b done %b expected %h lat 33 0 0 0",
                         i, f, a, b, res, lat, sb, ba, da, exp);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_zero();
        test_overflow();
        test_reset_mid();
        test_ignore_inputs();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
